// File: rtl/v_pkg.sv
// Shared types for the list update bus.
// Carries the command/key/size/id field types, the default hazard depth of the
// update pipe, and the packed per-producer request payload.
package v_pkg;

  typedef logic [1:0] cmd_t;
  typedef logic [7:0] key_t;
  typedef logic [3:0] size_t;
  typedef logic [2:0] id_t;

  // Read-to-write depth of v_update_pipe. A key must not be re-issued while
  // its previous update is still inside this window.
  localparam int UPD_HAZARD_CYCLES = 3;

  typedef struct packed {
    cmd_t  cmd;
    key_t  key;
    size_t size;
  } upd_req_t;

endpackage

// File: rtl/v_update_issue_if.sv
// Bundle of producer request handshakes and the registered update bus.
//   i_req_*   : per-producer request vectors (producer side drives)
//   o_req_rdy : per-producer accept (issuer drives, combinational)
//   o_upd_*_r : registered update bus toward v_update_pipe
//   o_idle    : issuer has nothing pending, no hazard window open, bus idle
//
// Handshake: a request from producer p transfers in the cycle where
// i_req_vld[p] and o_req_rdy[p] are both high. A producer may hold vld with a
// stable payload until accepted, or drop it (the request is then lost).
// i_req_vld must not depend combinationally on o_req_rdy. The update bus has
// no ready: o_upd_vld_r marks a one-cycle transaction and the data fields are
// meaningful only while it is high.
interface v_update_issue_if #(
  parameter int PROD_N = 4
);

  logic        [PROD_N-1:0] i_req_vld;
  v_pkg::cmd_t [PROD_N-1:0] i_req_cmd;
  v_pkg::key_t [PROD_N-1:0] i_req_key;
  v_pkg::size_t [PROD_N-1:0] i_req_size;
  logic        [PROD_N-1:0] o_req_rdy;

  logic         o_upd_vld_r;
  v_pkg::id_t   o_upd_prod_id_r;
  v_pkg::cmd_t  o_upd_cmd_r;
  v_pkg::key_t  o_upd_key_r;
  v_pkg::size_t o_upd_size_r;
  logic         o_idle;

  modport master (
    output i_req_vld, i_req_cmd, i_req_key, i_req_size,
    input  o_req_rdy, o_upd_vld_r, o_upd_prod_id_r, o_upd_cmd_r,
           o_upd_key_r, o_upd_size_r, o_idle
  );

  modport slave (
    input  i_req_vld, i_req_cmd, i_req_key, i_req_size,
    output o_req_rdy, o_upd_vld_r, o_upd_prod_id_r, o_upd_cmd_r,
           o_upd_key_r, o_upd_size_r, o_idle
  );

endinterface

// File: rtl/v_rr_arb.sv
// Combinational round-robin arbiter.
//   req     : request vector
//   ptr     : highest-priority index; search runs upward from here with wrap
//   gnt     : one-hot grant (all zero when no request)
//   gnt_idx : encoded grant index (0 when no request)
// The pointer register lives in the instantiating block.
module v_rr_arb #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/v_update_issue.sv
// Update bus transmitter: round-robin issue of producer requests onto the
// registered update bus, with a per-producer hazard window so one producer
// cannot re-issue while its last update is inside the pipe's RMW window.
//   clk, rst : clock, synchronous active-high reset
//   bus      : v_update_issue_if slave (requests in, update bus out)
module v_update_issue
  import v_pkg::*;
#(
  parameter int PROD_N        = 4,
  parameter int HAZARD_CYCLES = UPD_HAZARD_CYCLES
) (
  input logic             clk,
  input logic             rst,
  v_update_issue_if.slave bus
);

  localparam int IW = $clog2(PROD_N);
  // A zero-cycle window still needs a 1-bit counter to keep widths legal;
  // it is then loaded with 0 and never leaves 0.
  localparam int HW = (HAZARD_CYCLES > 0) ? $clog2(HAZARD_CYCLES + 1) : 1;
  localparam logic [HW-1:0] HZ_LOAD = HW'(HAZARD_CYCLES);

  if (PROD_N < 2 || PROD_N > (1 << $bits(id_t))) begin : g_bad_prod_n
    $error("v_update_issue: PROD_N must be in 2..2**$bits(id_t)");
  end

  logic [HW-1:0]         hz_q [PROD_N];
  logic [HW-1:0]         hz_d [PROD_N];
  logic [IW-1:0]         ptr_q, ptr_d;
  logic                  vld_q, vld_d;
  id_t                   id_q, id_d;
  upd_req_t              pl_q, pl_d;

  logic [PROD_N-1:0]     elig;
  logic [PROD_N-1:0]     gnt;
  logic [PROD_N-1:0]     rdy;
  logic [IW-1:0]         gnt_idx;
  upd_req_t [PROD_N-1:0] req_pl;
  logic                  hz_busy;

  always_comb begin
    elig   = '0;
    req_pl = '0;
    for (int p = 0; p < PROD_N; p++) begin
      // A counter that reaches 0 this cycle already allows a grant.
      elig[p]   = bus.i_req_vld[p] && (hz_q[p] == '0);
      req_pl[p] = '{cmd: bus.i_req_cmd[p], key: bus.i_req_key[p], size: bus.i_req_size[p]};
    end
  end

  v_rr_arb #(.N(PROD_N)) u_arb (
    .req     (elig),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // No accepts while in reset: nothing may be taken that reset then discards.
  assign rdy = rst ? '0 : gnt;

  always_comb begin
    ptr_d = ptr_q;
    vld_d = |rdy;
    id_d  = id_q;
    pl_d  = pl_q;
    if (|rdy) begin
      ptr_d = (gnt_idx == IW'(PROD_N - 1)) ? '0 : gnt_idx + 1'b1;
      id_d  = id_t'(gnt_idx);
      pl_d  = req_pl[gnt_idx];
    end
    for (int p = 0; p < PROD_N; p++) begin
      hz_d[p] = hz_q[p];
      if (rdy[p]) begin
        hz_d[p] = HZ_LOAD;
      end else if (hz_q[p] != '0) begin
        hz_d[p] = hz_q[p] - 1'b1;
      end
    end
  end

  always_comb begin
    hz_busy = 1'b0;
    for (int p = 0; p < PROD_N; p++) begin
      hz_busy = hz_busy | (hz_q[p] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      vld_q <= 1'b0;
      id_q  <= '0;
      pl_q  <= '0;
      for (int p = 0; p < PROD_N; p++) begin
        hz_q[p] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      vld_q <= vld_d;
      id_q  <= id_d;
      pl_q  <= pl_d;
      for (int p = 0; p < PROD_N; p++) begin
        hz_q[p] <= hz_d[p];
      end
    end
  end

  assign bus.o_req_rdy       = rdy;
  assign bus.o_upd_vld_r     = vld_q;
  assign bus.o_upd_prod_id_r = id_q;
  assign bus.o_upd_cmd_r     = pl_q.cmd;
  assign bus.o_upd_key_r     = pl_q.key;
  assign bus.o_upd_size_r    = pl_q.size;
  assign bus.o_idle          = ~(|bus.i_req_vld) & ~hz_busy & ~vld_q;

endmodule

// File: tb/tb_v_update_issue.sv
module tb_v_update_issue;
  import v_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  v_update_issue_if #(.PROD_N(4)) bus3 ();
  v_update_issue_if #(.PROD_N(4)) bus0 ();

  v_update_issue #(.PROD_N(4), .HAZARD_CYCLES(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  v_update_issue #(.PROD_N(4), .HAZARD_CYCLES(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  // Wrap-and-skip expectations, hand-derived: index c is the cycle after the
  // setup grant to producer 2 (ptr = 3), producers {1,3} valid throughout.
  int t3_rdy  [7] = '{8, 2, 0, 0, 8, 2, 0};
  int t3_vld  [7] = '{1, 1, 1, 0, 0, 1, 1};
  int t3_prod [7] = '{2, 3, 1, 1, 1, 3, 1};

  // ---------------- checker / drivers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    bus3.i_req_vld = '0;
    bus0.i_req_vld = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_payloads();
    for (int p = 0; p < 4; p++) begin
      bus3.i_req_cmd[p]  = cmd_t'(p);
      bus3.i_req_key[p]  = key_t'(16 + p);
      bus3.i_req_size[p] = size_t'(p + 1);
      bus0.i_req_cmd[p]  = cmd_t'(p);
      bus0.i_req_key[p]  = key_t'(16 + p);
      bus0.i_req_size[p] = size_t'(p + 1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus3.i_req_vld = '0;
    bus0.i_req_vld = '0;
    set_payloads();
    tick();
    tick();

    // Reset state: no accepts while rst is high even with every vld set.
    bus3.i_req_vld = 4'hF;
    settle();
    check("rst_rdy", 32'(bus3.o_req_rdy), 32'h0);
    tick();
    bus3.i_req_vld = '0;
    settle();
    check("rst_vld",  32'(bus3.o_upd_vld_r), 32'h0);
    check("rst_id",   32'(bus3.o_upd_prod_id_r), 32'h0);
    check("rst_cmd",  32'(bus3.o_upd_cmd_r), 32'h0);
    check("rst_key",  32'(bus3.o_upd_key_r), 32'h0);
    check("rst_size", 32'(bus3.o_upd_size_r), 32'h0);
    check("rst_idle", 32'(bus3.o_idle), 32'h1);
    rst = 1'b0;

    // Single producer 2 held for 12 cycles: grants at 0, 4, 8.
    for (int c = 0; c < 12; c++) begin
      tick();
      bus3.i_req_vld = 4'b0100;
      settle();
      check("t1_rdy", 32'(bus3.o_req_rdy), (c % 4 == 0) ? 32'h4 : 32'h0);
      check("t1_vld", 32'(bus3.o_upd_vld_r), (c >= 1 && (c - 1) % 4 == 0) ? 32'h1 : 32'h0);
      if (c >= 1 && (c - 1) % 4 == 0) begin
        check("t1_id",  32'(bus3.o_upd_prod_id_r), 32'h2);
        check("t1_key", 32'(bus3.o_upd_key_r), 32'h12);
        check("t1_size", 32'(bus3.o_upd_size_r), 32'h3);
      end
    end
    tick();
    bus3.i_req_vld = '0;
    settle();
    check("t1_idle", 32'(bus3.o_idle), 32'h1);

    // All producers continuously valid: 0,1,2,3,0,1,...
    do_reset();
    for (int c = 0; c < 10; c++) begin
      tick();
      bus3.i_req_vld = 4'hF;
      settle();
      check("t2_rdy", 32'(bus3.o_req_rdy), 32'(1 << (c % 4)));
      check("t2_vld", 32'(bus3.o_upd_vld_r), (c >= 1) ? 32'h1 : 32'h0);
      if (c >= 1) begin
        check("t2_id",  32'(bus3.o_upd_prod_id_r), 32'((c - 1) % 4));
        check("t2_key", 32'(bus3.o_upd_key_r), 32'(16 + (c - 1) % 4));
        check("t2_cmd", 32'(bus3.o_upd_cmd_r), 32'((c - 1) % 4));
      end
    end

    // Wrap and skip: bring ptr to 3 with one grant to producer 2.
    do_reset();
    tick();
    bus3.i_req_vld = 4'b0100;
    settle();
    check("t3_setup", 32'(bus3.o_req_rdy), 32'h4);
    for (int c = 0; c < 7; c++) begin
      tick();
      bus3.i_req_vld = 4'b1010;
      settle();
      check("t3_rdy", 32'(bus3.o_req_rdy), 32'(t3_rdy[c]));
      check("t3_vld", 32'(bus3.o_upd_vld_r), 32'(t3_vld[c]));
      check("t3_id",  32'(bus3.o_upd_prod_id_r), 32'(t3_prod[c]));
      check("t3_key", 32'(bus3.o_upd_key_r), 32'(16 + t3_prod[c]));
    end

    // Hazard/eligibility race: producer 0 back at t+4 with ptr on 1.
    do_reset();
    tick();
    bus3.i_req_vld = 4'b0001;
    settle();
    check("t4_rdy_t0", 32'(bus3.o_req_rdy), 32'h1);
    tick();
    bus3.i_req_vld = '0;
    settle();
    check("t4_rdy_t1",  32'(bus3.o_req_rdy), 32'h0);
    check("t4_vld_t1",  32'(bus3.o_upd_vld_r), 32'h1);
    check("t4_id_t1",   32'(bus3.o_upd_prod_id_r), 32'h0);
    check("t4_idle_t1", 32'(bus3.o_idle), 32'h0);
    tick();
    tick();
    settle();
    check("t4_vld_t3",  32'(bus3.o_upd_vld_r), 32'h0);
    check("t4_idle_t3", 32'(bus3.o_idle), 32'h0);
    tick();
    bus3.i_req_vld = 4'b0011;
    settle();
    check("t4_rdy_t4", 32'(bus3.o_req_rdy), 32'h2);
    tick();
    settle();
    check("t4_rdy_t5", 32'(bus3.o_req_rdy), 32'h1);
    check("t4_id_t5",  32'(bus3.o_upd_prod_id_r), 32'h1);
    tick();
    bus3.i_req_vld = '0;
    settle();
    check("t4_vld_t6", 32'(bus3.o_upd_vld_r), 32'h1);
    check("t4_id_t6",  32'(bus3.o_upd_prod_id_r), 32'h0);

    // Reset mid-stream under full load.
    do_reset();
    for (int c = 0; c < 2; c++) begin
      tick();
      bus3.i_req_vld = 4'hF;
      settle();
      check("t5_rdy_pre", 32'(bus3.o_req_rdy), 32'(1 << c));
    end
    tick();
    rst = 1'b1;
    settle();
    check("t5_rdy_rst", 32'(bus3.o_req_rdy), 32'h0);
    tick();
    rst = 1'b0;
    settle();
    check("t5_vld_post", 32'(bus3.o_upd_vld_r), 32'h0);
    check("t5_id_post",  32'(bus3.o_upd_prod_id_r), 32'h0);
    check("t5_key_post", 32'(bus3.o_upd_key_r), 32'h0);
    check("t5_rdy_c3",   32'(bus3.o_req_rdy), 32'h1);
    for (int c = 1; c < 4; c++) begin
      tick();
      settle();
      check("t5_rdy_post", 32'(bus3.o_req_rdy), 32'(1 << c));
    end
    tick();
    bus3.i_req_vld = '0;

    // HAZARD_CYCLES = 0 build: producer 0 every cycle.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      tick();
      bus0.i_req_vld = 4'b0001;
      settle();
      check("t6_rdy", 32'(bus0.o_req_rdy), 32'h1);
      check("t6_vld", 32'(bus0.o_upd_vld_r), (c >= 1) ? 32'h1 : 32'h0);
    end
    tick();
    bus0.i_req_vld = '0;
    settle();
    check("t6_rdy_drop",  32'(bus0.o_req_rdy), 32'h0);
    check("t6_vld_drop",  32'(bus0.o_upd_vld_r), 32'h1);
    check("t6_id_drop",   32'(bus0.o_upd_prod_id_r), 32'h0);
    check("t6_key_drop",  32'(bus0.o_upd_key_r), 32'h10);
    check("t6_idle_drop", 32'(bus0.o_idle), 32'h0);
    tick();
    settle();
    check("t6_vld_after",  32'(bus0.o_upd_vld_r), 32'h0);
    check("t6_idle_after", 32'(bus0.o_idle), 32'h1);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
